// File: rtl/mips32_shift_pipe.sv
// mips32_shift_pipe: pipelined barrel shifter for the MIPS32 execute stage.
// Stage k resolves shift-amount bit k, so a result takes SHAMTW register stages.
// Every stage advances together whenever the output register is empty or
// being drained, which gives full backpressure without per-stage stalls.
module mips32_shift_pipe #(
  parameter int DATAWIDTH = 32,
  localparam int SHAMTW = $clog2(DATAWIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic                 in_arith,
  input  logic [SHAMTW-1:0]    in_shamt,
  input  logic [DATAWIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic                 busy
);

  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SR  = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  // The last stage only needs data and valid; control stops one stage earlier.
  localparam int NCTL = SHAMTW - 1;

  logic                 valid_q [SHAMTW];
  logic                 valid_d [SHAMTW];
  logic [DATAWIDTH-1:0] data_q  [SHAMTW];
  logic [DATAWIDTH-1:0] data_d  [SHAMTW];
  logic [1:0]           mode_q  [NCTL];
  logic [1:0]           mode_d  [NCTL];
  logic                 fill_q  [NCTL];
  logic                 fill_d  [NCTL];
  logic [SHAMTW-1:0]    shamt_q [NCTL];
  logic [SHAMTW-1:0]    shamt_d [NCTL];

  // Per-stage source operands: inputs for S0, previous stage for the rest.
  logic                 src_valid [SHAMTW];
  logic [DATAWIDTH-1:0] src_data  [SHAMTW];
  logic [1:0]           src_mode  [SHAMTW];
  logic                 src_fill  [SHAMTW];
  logic [SHAMTW-1:0]    src_shamt [SHAMTW];

  logic adv;

  // One fixed-distance shift step; fill carries the operand sign captured at entry.
  function automatic logic [DATAWIDTH-1:0] shift_step(
    input logic [DATAWIDTH-1:0] d,
    input logic [1:0]           mode,
    input logic                 fill,
    input logic                 en,
    input int                   amt
  );
    logic [DATAWIDTH-1:0] fill_mask;
    fill_mask = ~({DATAWIDTH{1'b1}} >> amt);
    if (!en) return d;
    case (mode)
      MODE_SLL: return d << amt;
      MODE_SR:  return (d >> amt) | (fill ? fill_mask : '0);
      MODE_ROR: return (d >> amt) | (d << (DATAWIDTH - amt));
      default:  return d;
    endcase
  endfunction

  assign adv       = !valid_q[SHAMTW-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[SHAMTW-1];
  assign out_data  = data_q[SHAMTW-1];

  assign src_valid[0] = in_valid;
  assign src_data[0]  = in_data;
  assign src_mode[0]  = in_mode;
  assign src_fill[0]  = in_arith & in_data[DATAWIDTH-1];
  assign src_shamt[0] = in_shamt;

  for (genvar k = 1; k < SHAMTW; k++) begin : g_src
    assign src_valid[k] = valid_q[k-1];
    assign src_data[k]  = data_q[k-1];
    assign src_mode[k]  = mode_q[k-1];
    assign src_fill[k]  = fill_q[k-1];
    assign src_shamt[k] = shamt_q[k-1];
  end

  // Next-state for every stage: load from predecessor on advance, else hold.
  always_comb begin
    for (int k = 0; k < SHAMTW; k++) begin
      valid_d[k] = adv ? src_valid[k] : valid_q[k];
      data_d[k]  = adv ? shift_step(src_data[k], src_mode[k], src_fill[k],
                                    src_shamt[k][k], 1 << k)
                       : data_q[k];
    end
    for (int k = 0; k < NCTL; k++) begin
      mode_d[k]  = adv ? src_mode[k]  : mode_q[k];
      fill_d[k]  = adv ? src_fill[k]  : fill_q[k];
      shamt_d[k] = adv ? src_shamt[k] : shamt_q[k];
    end
  end

  // busy reflects any valid entry anywhere in the pipe.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < SHAMTW; k++) busy = busy | valid_q[k];
  end

  // Stage registers; reset discards every in-flight entry immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SHAMTW; k++) begin
        valid_q[k] <= 1'b0;
        data_q[k]  <= '0;
      end
      for (int k = 0; k < NCTL; k++) begin
        mode_q[k]  <= '0;
        fill_q[k]  <= 1'b0;
        shamt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHAMTW; k++) begin
        valid_q[k] <= valid_d[k];
        data_q[k]  <= data_d[k];
      end
      for (int k = 0; k < NCTL; k++) begin
        mode_q[k]  <= mode_d[k];
        fill_q[k]  <= fill_d[k];
        shamt_q[k] <= shamt_d[k];
      end
    end
  end

endmodule

// File: tb/tb_mips32_shift_pipe.sv
// Directed and random bench for mips32_shift_pipe (DATAWIDTH=32, 5 stages).
module tb_mips32_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic        in_arith;
  logic [4:0]  in_shamt;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q [$];

  mips32_shift_pipe #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_arith(in_arith), .in_shamt(in_shamt), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Directed table: data, mode, arith, shamt, hand-computed result.
  localparam int ND = 12;
  logic [31:0] dir_data  [ND] = '{32'hF0000000, 32'hF0000000, 32'h00000003, 32'h12345678,
                                  32'h80000000, 32'h12345678, 32'h12345678, 32'h12345678,
                                  32'h7FFFFFFF, 32'h80000000, 32'hF0000000, 32'hAAAAAAAA};
  logic [1:0]  dir_mode  [ND] = '{2'd2, 2'd2, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd3,
                                  2'd2, 2'd1, 2'd3, 2'd1};
  logic        dir_arith [ND] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b1, 1'b1, 1'b1};
  logic [4:0]  dir_shamt [ND] = '{5'd4, 5'd4, 5'd31, 5'd17, 5'd31, 5'd0, 5'd4, 5'd8,
                                  5'd31, 5'd0, 5'd4, 5'd1};
  logic [31:0] dir_exp   [ND] = '{32'hFF000000, 32'h0F000000, 32'h80000000, 32'h12345678,
                                  32'hFFFFFFFF, 32'h12345678, 32'h23456780, 32'h78123456,
                                  32'h00000000, 32'h80000000, 32'h0F000000, 32'h55555554};

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] m,
                                            input logic a, input logic [4:0] s);
    case (m)
      2'd0: return d;
      2'd1: return d << s;
      2'd2: return a ? 32'($signed(d) >>> s) : (d >> s);
      default: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  task automatic drive_op(input logic [31:0] d, input logic [1:0] m,
                          input logic a, input logic [4:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_arith = a;
    in_shamt = s;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_mode = '0; in_arith = 1'b0; in_shamt = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 00000000", out_data); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_rotate_latency();
    int cyc;
    drive_op(32'h80000001, 2'd3, 1'b0, 5'd1);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL lat_in_ready: got %b want 1", in_ready); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc !== 5) $display("FAIL lat_cycles: got %0d want 5", cyc); else n_pass++;
    n_checks++; if (out_data !== 32'hC0000000) $display("FAIL lat_ror_data: got %h want c0000000", out_data); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL lat_drain: got busy=%b out_valid=%b want 0/0", busy, out_valid); else n_pass++;
  endtask

  task automatic test_directed();
    int rcv = 0;
    for (int c = 0; c < ND + 20; c++) begin
      if (c < ND) drive_op(dir_data[c], dir_mode[c], dir_arith[c], dir_shamt[c]);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      if (out_valid) begin
        if (rcv < ND) begin
          n_checks++;
          if (out_data !== dir_exp[rcv]) $display("FAIL directed_%0d: got %h want %h", rcv, out_data, dir_exp[rcv]);
          else n_pass++;
        end
        rcv++;
      end
      @(negedge clk);
    end
    n_checks++; if (rcv !== ND) $display("FAIL directed_count: got %0d want %0d", rcv, ND); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rcv = 0, sent = 0, drops = 0, gaps = 0, last_c = 0;
    logic [31:0] e;
    logic [31:0] d;
    exp_q.delete();
    for (int c = 0; c < 30; c++) begin
      if (sent < 8) begin
        d = 32'h01234567 ^ (32'(sent) * 32'h11111111);
        drive_op(d, 2'(sent % 4), sent[0], 5'(sent * 3 + 1));
      end else in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      if (in_ready !== 1'b1) drops++;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (out_data !== e) $display("FAIL b2b_data_%0d: got %h want %h", rcv, out_data, e);
        else n_pass++;
        if (rcv > 0 && c != last_c + 1) gaps++;
        last_c = c;
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_mode, in_arith, in_shamt));
        sent++;
      end
      @(negedge clk);
    end
    n_checks++; if (rcv !== 8) $display("FAIL b2b_count: got %0d want 8", rcv); else n_pass++;
    n_checks++; if (gaps !== 0) $display("FAIL b2b_consecutive: got %0d gaps want 0", gaps); else n_pass++;
    n_checks++; if (drops !== 0) $display("FAIL b2b_in_ready: got %0d drops want 0", drops); else n_pass++;
  endtask

  task automatic test_backpressure();
    int rcv = 0, sent = 0;
    logic have_held = 1'b0;
    logic [31:0] held = '0;
    logic [31:0] e;
    exp_q.delete();
    for (int c = 0; c < 40; c++) begin
      if (sent < 10) drive_op(32'hDEADBEEF + 32'(sent) * 32'h01000001, 2'(sent % 4),
                              sent[0], 5'((sent * 7) % 32));
      else in_valid = 1'b0;
      out_ready = !(c >= 5 && c < 8);
      #1;
      if (c == 5) begin
        n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_full: got out_valid=%b want 1", out_valid); else n_pass++;
      end
      if (out_valid && !out_ready) begin
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
        if (have_held) begin
          n_checks++; if (out_data !== held) $display("FAIL bp_hold: got %h want %h", out_data, held); else n_pass++;
        end
        held = out_data;
        have_held = 1'b1;
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (out_data !== e) $display("FAIL bp_data_%0d: got %h want %h", rcv, out_data, e);
        else n_pass++;
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_mode, in_arith, in_shamt));
        sent++;
      end
      @(negedge clk);
    end
    n_checks++; if (rcv !== 10) $display("FAIL bp_count: got %0d want 10", rcv); else n_pass++;
  endtask

  task automatic test_midflight_reset();
    int stale = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0 || c == 3 || c == 4) drive_op(32'h13579BDF + 32'(c), 2'd1, 1'b0, 5'(c));
      else in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL mid_preload: got out_valid=%b busy=%b want 1/1", out_valid, busy); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    n_checks++; if (stale !== 0) $display("FAIL mid_stale: got %0d stale cycles want 0", stale); else n_pass++;
  endtask

  task automatic test_random();
    int rcv = 0, sent = 0, c = 0;
    logic [31:0] e;
    exp_q.delete();
    while (rcv < 10000 && c < 60000) begin
      if (sent < 10000 && $urandom_range(0, 3) != 0)
        drive_op($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)));
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_checks++;
        if (out_data !== e) $display("FAIL rand_%0d: got %h want %h", rcv, out_data, e);
        else n_pass++;
        rcv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_shift(in_data, in_mode, in_arith, in_shamt));
        sent++;
      end
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    n_checks++; if (rcv !== 10000) $display("FAIL rand_count: got %0d want 10000", rcv); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_rotate_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips32_shift_pipe.md
# mips32_shift_pipe

Pipelined, parametrised shifter for the MIPS32 execute stage. It accepts one operand per cycle with mode and shift amount and resolves the shift over log2(DATAWIDTH) register stages, one shift-amount bit per stage. It supports pass, logical left, logical/arithmetic right and rotate right. Valid/ready handshakes on both sides give it full backpressure, so it can sit between issue and writeback without an external stall network.

## Interface
- DATAWIDTH, 32, operand/result width; power of two, >= 4
- SHAMTW, $clog2(DATAWIDTH), shift-amount width and pipeline depth (derived; not overridden)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand presented
- in_ready  output  1  pipeline accepts operand this cycle
- in_mode  input  2  00 pass, 01 shift left logical, 10 shift right, 11 rotate right
- in_arith  input  1  when mode=10: 1 arithmetic (sign fill), 0 logical (zero fill); ignored otherwise
- in_shamt  input  SHAMTW  shift amount, 0..DATAWIDTH-1
- in_data  input  DATAWIDTH  operand
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  DATAWIDTH  shifted result
- busy  output  1  any stage holds a valid entry

## Operation
- Stages are S0..S(SHAMTW-1). Each stage registers data, mode, arith, remaining shamt bits and a valid bit.
- Stage k applies a shift of 2^k when shamt[k]=1; otherwise it passes data through.
  - Mode 01: shift left, zero fill.
  - Mode 10: shift right, fill = arith ? original operand MSB : 0. The original MSB is captured at entry and carried in the pipe.
  - Mode 11: rotate right.
  - Mode 00: data passes unchanged regardless of shamt.
- out_data/out_valid are the registers of the last stage.
- Global advance: adv = !out_valid || out_ready. When adv=1, every stage loads from its predecessor, and S0 loads from the inputs with valid = in_valid. When adv=0, all stages hold.
- in_ready = adv, combinational from out_valid/out_ready only. It does not depend on in_valid.
- A transfer occurs on in_valid && in_ready. An output transfer occurs on out_valid && out_ready.
- Bubbles propagate as valid=0 entries. Bubbles are not compressed; throughput is one result per cycle while out_ready=1.
- Ordering is strictly FIFO; no reordering or dropping.
- busy = OR of all stage valid bits.

## Timing
- Reset (async assert, sync release by the clock domain): all valids 0, out_valid=0, out_data=0, busy=0. in_ready=1 immediately after reset.
- Latency: an operand accepted at edge N appears with out_valid=1 after edge N+SHAMTW-1. That is SHAMTW cycles, 5 for DATAWIDTH=32, with out_ready held high.
- out_data is stable while out_valid=1 && out_ready=0, and may change only after the accepting edge.
- Simultaneous accept and output with a full pipe and out_ready=1: both transfers occur in the same cycle.
- out_ready=0 with out_valid=1: in_ready=0, and the input is not consumed even if S0 is empty.
- rst asserted mid-operation: all in-flight entries are discarded at once; nothing reaches the output after release.
- shamt=0 in any mode returns in_data unchanged.
- Mode 10 with arith=1 and shamt=DATAWIDTH-1 yields all copies of the sign bit.

## Test plan
- Reset then single op: in_data=0x80000001, mode=11, shamt=1 -> out_data=0xC0000000, out_valid rises exactly 5 cycles after accept.
- Arithmetic versus logical right on 0xF0000000, shamt=4:
  - arith=1 -> 0xFF000000.
  - arith=0 -> 0x0F000000.
  - Mode 01, shamt=31 on 0x00000003 -> 0x80000000.
- Streaming: 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, in order; in_ready never drops.
- Backpressure: fill the pipe, then drop out_ready for 3 cycles.
  - in_ready=0 and out_data is held.
  - On release, the remaining results drain in order with none lost or duplicated.
- Mid-flight reset: assert rst with 3 entries in flight -> out_valid=0, busy=0 immediately, and no stale result appears after release.
- Mode 00 with shamt=17 on 0x12345678 -> 0x12345678. Random mode/shamt/data against a reference model over 10k ops shows no mismatches.
